// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one registered XOR stage.
// Valid/ready: a result moves downstream on any rising edge where out_valid and out_ready are both high.
module xor_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_bus,
    input  logic [N_REQ*WIDTH-1:0]   b_bus,
    input  logic                     out_ready,
    output logic [N_REQ-1:0]         gnt,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [IDW-1:0]           out_id,
    output logic [15:0]              xfer_count,
    output logic                     dbg_state_o
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   ptr_q;
    logic [15:0]      xfer_q;

    logic             can_accept;
    logic             sel_found;
    logic [IDW-1:0]   sel_idx;
    logic [IDW-1:0]   cand;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [IDW-1:0]   ptr_d;
    int               idx;

    // The output slot frees up either when empty or when its result leaves this cycle.
    assign can_accept = rst_n && ((state_q == EMPTY) || out_ready);

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            cand = IDW'(idx);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign accept = can_accept && sel_found;

    always_comb begin
        gnt   = '0;
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx == IDW'(i)) begin
                gnt[i] = accept;
                sel_a  = a_bus[i*WIDTH +: WIDTH];
                sel_b  = b_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_d = (sel_idx == IDW'(N_REQ - 1)) ? '0 : sel_idx + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            xfer_q  <= '0;
        end else begin
            if ((state_q == FULL) && out_ready && (xfer_q != 16'hFFFF))
                xfer_q <= xfer_q + 16'd1;
            if (accept) begin
                state_q <= FULL;
                data_q  <= sel_a ^ sel_b;
                id_q    <= sel_idx;
                ptr_q   <= ptr_d;
            end else if ((state_q == FULL) && out_ready) begin
                state_q <= EMPTY;
            end
        end
    end

    assign out_valid   = (state_q == FULL);
    assign out_data    = data_q;
    assign out_id      = id_q;
    assign xfer_count  = xfer_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Bench for xor_share_arbiter: directed scenarios plus random traffic against a
// queue-based model of the output slot and a round-robin pointer.
module tb_xor_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*W-1:0]  a_bus;
    logic [N*W-1:0]  b_bus;
    logic            out_ready;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [IW-1:0]   out_id;
    logic [15:0]     xfer_count;
    logic            dbg_state_o;

    xor_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .out_ready(out_ready), .gnt(gnt), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .xfer_count(xfer_count), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [IW+W-1:0] exp_q[$];   // {id, data} of the result the output slot should hold
    int m_ptr = 0;
    int m_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++)
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // Starts and ends on a falling edge; one full clock of stimulus and checking.
    task automatic drive(input logic [N-1:0] r, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input logic rdy);
        bit          full;
        int          w;
        logic [N-1:0] eg;
        req = r; a_bus = a; b_bus = b; out_ready = rdy;
        #1;
        full = (exp_q.size() != 0);
        w    = (!full || rdy) ? pick(r) : -1;
        eg   = '0;
        if (w >= 0) eg[w] = 1'b1;
        check("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        if (full && rdy) begin
            void'(exp_q.pop_front());
            if (m_cnt < 65535) m_cnt++;
        end
        if (w >= 0) begin
            exp_q.push_back({IW'(w), a[w*W +: W] ^ b[w*W +: W]});
            m_ptr = (w + 1) % N;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("dbg_state", 32'(dbg_state_o), 32'(exp_q.size() != 0));
        check("xfer_count", 32'(xfer_count), 32'(m_cnt));
        if (exp_q.size() != 0) begin
            check("out_data", 32'(out_data), 32'(exp_q[0][W-1:0]));
            check("out_id", 32'(out_id), 32'(exp_q[0][IW+W-1:W]));
        end
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks the outputs clear with no clock edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        req = 4'b1111;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(xfer_count), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        exp_q.delete();
        m_ptr = 0;
        m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        req = '0;
        rst_n = 1'b1;
    endtask

    logic [15:0] saved;
    logic [7:0]  pa [4];
    logic [7:0]  pb [4];

    initial begin
        rst_n = 1'b0; req = '0; a_bus = '0; b_bus = '0; out_ready = 1'b0;
        #1;
        check("init_valid", 32'(out_valid), 32'd0);
        check("init_id", 32'(out_id), 32'd0);
        check("init_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request on requester 2
        drive(4'b0100, 32'h00A5_0000, 32'h000F_0000, 1'b1);
        check("single_data", 32'(out_data), 32'hAA);
        check("single_id", 32'(out_id), 32'd2);
        drive(4'b0000, '0, '0, 1'b1);
        check("single_count", 32'(xfer_count), 32'd1);

        // Fairness from a fresh pointer
        async_reset();
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, $urandom, $urandom, 1'b1);
            check("fair_id", 32'(out_id), 32'(k % 4));
        end

        // Backpressure: hold 3C from requester 3, pointer then wraps to 0
        drive(4'b1000, 32'h3C00_0000, 32'h0, 1'b1);
        saved = xfer_count;
        for (int k = 0; k < 5; k++) begin
            drive(4'b0011, 32'h0000_1234, 32'h0000_4321, 1'b0);
            check("bp_data", 32'(out_data), 32'h3C);
        end
        check("bp_count", 32'(xfer_count), 32'(saved));
        drive(4'b0011, 32'h0000_1234, 32'h0000_4321, 1'b1);
        check("bp_release_id", 32'(out_id), 32'd0);

        // Drain, then out_ready pulses while empty
        drive(4'b0000, '0, '0, 1'b1);
        saved = xfer_count;
        for (int k = 0; k < 3; k++) drive(4'b0000, '0, '0, 1'(k % 2));
        check("drain_count", 32'(xfer_count), 32'(saved));

        // Reset while full
        drive(4'b0001, 32'h55, 32'h0F, 1'b0);
        async_reset();
        drive(4'b1000, $urandom, $urandom, 1'b1);
        drive(4'b1001, $urandom, $urandom, 1'b1);
        check("post_rst_id", 32'(out_id), 32'd0);

        // XOR truth table on requester 1
        pa = '{8'h00, 8'h00, 8'hFF, 8'hFF};
        pb = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        drive(4'b0000, '0, '0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(4'b0010, {16'h0, pa[k], 8'h0}, {16'h0, pb[k], 8'h0}, 1'b1);
            check("truth_data", 32'(out_data), 32'(pa[k] ^ pb[k]));
        end

        // Random traffic
        for (int k = 0; k < 400; k++)
            drive(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 3) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
